featuremap_layer_sched: RTL and testbench
=========================================

# featuremap_layer_sched

Sequencer for one convolution layer's feature-map bank. Streams a stored WIDTH×WIDTH RGB image from the image RAM into the shared input-FIFO write port of all filter instances, inserting the one-pixel zero border on the fly to form a (WIDTH+2)×(WIDTH+2) padded raster. It then counts each filter's result pulses and signals layer completion. It sits between the image RAM and the featuremap_conv2d_* filter bank.

## Interface
- DATA_WIDTH, 32, width of one fp32 channel word
- WIDTH, 32, unpadded image side length
- ADDR_WIDTH, 10, image RAM address width; must satisfy 2^ADDR_WIDTH ≥ WIDTH*WIDTH
- NUM_FILTERS, 16, number of filter instances sharing the input stream
- CNT_WIDTH, 11, result-counter width; must hold WIDTH*WIDTH
---
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  level-sampled; begins a layer when sampled high in IDLE
- img_rd_en  out  1  image RAM read enable
- img_rd_addr  out  ADDR_WIDTH  image RAM address, raster order
- img_rd_data  in  DATA_WIDTH*3  {B,G,R} pixel; valid one cycle after img_rd_en
- fifo_full  in  1  almost-full from the filter FIFOs; asserted with ≥1 free slot remaining
- data_out  out  DATA_WIDTH*3  {B,G,R} word to the filter FIFOs
- data_fifo_wren  out  1  write strobe for data_out
- fm_valid  in  NUM_FILTERS  per-filter result-valid pulses
- busy  out  1  high from FEED through DONE
- done  out  1  one-cycle pulse when the layer completes
- err  out  1  sticky; set by an fm_valid pulse on a filter whose count is already complete

## Operation
- FSM states: IDLE, FEED, DRAIN, DONE.
  - IDLE→FEED when start=1. start is ignored in every other state.
  - FEED→DRAIN after the last padded position (WIDTH+1, WIDTH+1) is issued.
  - DRAIN→DONE once the final write has left the pipeline and every filter counter equals WIDTH*WIDTH.
  - DONE→IDLE unconditionally after one cycle.
- Scan counters r, c run over 0..WIDTH+1, with c fastest.
  - A position advances only in FEED with fifo_full=0. While fifo_full=1, no issue and no advance.
- Padding:
  - Position is border if r=0, r=WIDTH+1, c=0 or c=WIDTH+1. A border position issues no read and writes all-zero (fp32 +0.0 in every channel).
  - Interior positions assert img_rd_en with img_rd_addr=(r-1)*WIDTH+(c-1).
- Write stage: one register stage behind issue.
  - data_fifo_wren=1 one cycle after each issue.
  - data_out = img_rd_data for interior positions, 0 for border positions.
  - The single in-flight write during a stall is legal because of the fifo_full margin.
- Result counters: one per filter, CNT_WIDTH bits.
  - Each fm_valid bit increments its counter while the counter is < WIDTH*WIDTH.
  - A pulse at a full counter leaves the counter unchanged and sets err.
  - Counters are cleared on IDLE→FEED. err is cleared only by rst or by IDLE→FEED.
- fm_valid is counted in FEED, DRAIN and DONE. Pulses in IDLE set err.
- busy=1 in FEED, DRAIN and DONE. done=1 only in DONE.

## Timing
- Reset values: img_rd_en=0, img_rd_addr=0, data_out=0, data_fifo_wren=0, busy=0, done=0, err=0. State is IDLE; r, c and all counters are 0.
- rst mid-layer clears everything immediately (asynchronous). In-flight writes are dropped. A new start is required.
- start sampled at edge 0 → FEED from cycle 1. Position k (k=0..(WIDTH+2)²-1) is issued in cycle 1+k when no stall occurs.
  - img_rd_en/img_rd_addr are registered outputs valid in the issue cycle.
  - data_fifo_wren is valid in cycle 2+k.
- Each stall cycle (fifo_full=1 in FEED) delays all later issues by one cycle. fifo_full has no effect on the write already in flight.
- With WIDTH=32 and no stalls: 1156 writes in cycles 2..1157. State enters DRAIN at cycle 1157.
- done is asserted the cycle after the completing condition holds in DRAIN. If the counters complete during FEED, done follows the last write by 2 cycles.
- Simultaneous fm_valid on all filters in one cycle: every counter increments in that cycle.

## Test plan
- WIDTH=4, RAM word i = {i+200,i+100,i} per channel, start pulse → 36 writes in cycles 2..37; ring of 20 zeros; interior writes in raster order with R=0..15; img_rd_addr sequence 0..15; 16 reads total.
- WIDTH=4, fifo_full high for cycles 10–14 → exactly one write in cycle 10, none in 11–15; write sequence identical to the unstalled case and still 36 writes; no duplicate or missing address.
- NUM_FILTERS=2, filter0 gives 16 pulses, filter1 gives 15 → stays in DRAIN with done=0; filter1's 16th pulse at cycle t → done=1 at t+1 only, busy=0 at t+2.
- start held high throughout the layer → ignored while busy; a second layer starts only from IDLE; counters and err are cleared at that restart.
- 17th fm_valid pulse on filter0 → err=1 and stays set; counter stays at 16; done timing unaffected.
- rst asserted mid-FEED (cycle 20) → all outputs 0 in the same cycle; after release, start → a clean full 36-write sequence.

Source files
------------

// File: rtl/featuremap_layer_sched.sv
// Feature-map layer sequencer: streams a stored WIDTHxWIDTH RGB image with a one-pixel zero border
// into the shared filter FIFO write port, then waits until every filter has produced WIDTH*WIDTH results.
module featuremap_layer_sched #(
    parameter int DATA_WIDTH  = 32,
    parameter int WIDTH       = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int NUM_FILTERS = 16,
    parameter int CNT_WIDTH   = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    img_rd_en,
    output logic [ADDR_WIDTH-1:0]   img_rd_addr,
    input  logic [DATA_WIDTH*3-1:0] img_rd_data,
    input  logic                    fifo_full,
    output logic [DATA_WIDTH*3-1:0] data_out,
    output logic                    data_fifo_wren,
    input  logic [NUM_FILTERS-1:0]  fm_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int POS_WIDTH = $clog2(WIDTH + 2);
    localparam logic [POS_WIDTH-1:0] POS_LAST = POS_WIDTH'(WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(WIDTH * WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                  state_q;
    logic [POS_WIDTH-1:0]    r_q, c_q;
    logic                    rd_en_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic                    wr_q;
    logic                    wr_border_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;
    logic [CNT_WIDTH-1:0]    cnt_q [NUM_FILTERS];
    logic [CNT_WIDTH-1:0]    cnt_d [NUM_FILTERS];
    logic                    err_d;
    logic                    all_full_d;
    logic [POS_WIDTH-1:0]    r_d, c_d;
    logic                    interior_d;
    logic                    layer_start;

    assign layer_start = (state_q == ST_IDLE) && start;

    // Next scan position; rd_en_q doubles as the "current position is interior" flag.
    always_comb begin
        r_d = r_q;
        c_d = c_q + POS_WIDTH'(1);
        if (c_q == POS_LAST) begin
            r_d = r_q + POS_WIDTH'(1);
            c_d = '0;
        end
        interior_d = (r_d != '0) && (r_d != POS_LAST) && (c_d != '0) && (c_d != POS_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            r_q         <= '0;
            c_q         <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            wr_q        <= 1'b0;
            wr_border_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_FEED;
                        busy_q    <= 1'b1;
                        r_q       <= '0;
                        c_q       <= '0;
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                    end
                end
                ST_FEED: begin
                    if (!fifo_full) begin
                        wr_q        <= 1'b1;
                        wr_border_q <= !rd_en_q;
                        rd_addr_q   <= rd_addr_q + ADDR_WIDTH'(rd_en_q);
                        if ((r_q == POS_LAST) && (c_q == POS_LAST)) begin
                            state_q <= ST_DRAIN;
                            rd_en_q <= 1'b0;
                        end else begin
                            r_q     <= r_d;
                            c_q     <= c_d;
                            rd_en_q <= interior_d;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The last write must have left the pipeline before the layer may finish.
                    if (!wr_q && all_full_d) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Completion is judged on the updated counts so done follows the final pulse by one cycle.
    always_comb begin
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        all_full_d = 1'b1;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            if (fm_valid[i]) begin
                if (state_q == ST_IDLE) begin
                    err_d = 1'b1;
                end else if (cnt_q[i] < CNT_FULL) begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
            if (cnt_d[i] != CNT_FULL) begin
                all_full_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
            for (int i = 0; i < NUM_FILTERS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (layer_start) begin
            err_q <= 1'b0;
            for (int i = 0; i < NUM_FILTERS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (err_d) begin
                err_q <= 1'b1;
            end
            for (int i = 0; i < NUM_FILTERS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign img_rd_en      = rd_en_q;
    assign img_rd_addr    = rd_addr_q;
    assign data_fifo_wren = wr_q;
    assign data_out       = (wr_q && !wr_border_q) ? img_rd_data : '0;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_featuremap_layer_sched.sv
// Scoreboard bench for featuremap_layer_sched at WIDTH=4, two filters: expected writes, reads,
// done pulses and status probes are queued up front and a negedge monitor consumes them.
module tb_featuremap_layer_sched;

    localparam int DW     = 32;
    localparam int W      = 4;
    localparam int AW     = 10;
    localparam int NF     = 2;
    localparam int CW     = 11;
    localparam int PERIOD = 10;
    localparam int SIDE   = W + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              img_rd_en;
    logic [AW-1:0]     img_rd_addr;
    logic [DW*3-1:0]   img_rd_data = '0;
    logic              fifo_full;
    logic [DW*3-1:0]   data_out;
    logic              data_fifo_wren;
    logic [NF-1:0]     fm_valid;
    logic              busy;
    logic              done;
    logic              err;

    typedef struct {
        logic [DW*3-1:0] data;
        int              cyc;
    } wr_t;

    typedef struct {
        int   cyc;
        int   sig;
        logic val;
    } probe_t;

    wr_t     wrQ[$];
    int      addrQ[$];
    int      doneQ[$];
    probe_t  probeQ[$];

    int      compared   = 0;
    int      mismatched = 0;
    longint  t0         = 0;
    bit      active     = 1'b0;
    int      fLo[NF][2];
    int      fHi[NF][2];
    int      stallLo    = 0;
    int      stallHi    = 0;
    int      rstAt      = 0;
    logic [DW*3-1:0] mem [0:(1<<AW)-1];

    featuremap_layer_sched #(
        .DATA_WIDTH (DW),
        .WIDTH      (W),
        .ADDR_WIDTH (AW),
        .NUM_FILTERS(NF),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .img_rd_en     (img_rd_en),
        .img_rd_addr   (img_rd_addr),
        .img_rd_data   (img_rd_data),
        .fifo_full     (fifo_full),
        .data_out      (data_out),
        .data_fifo_wren(data_fifo_wren),
        .fm_valid      (fm_valid),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #(PERIOD/2) clk = ~clk;

    // Image RAM with one-cycle read latency; word i holds {B,G,R} = {i+200, i+100, i}.
    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = '0;
        end
        for (int i = 0; i < W * W; i++) begin
            mem[i] = {DW'(i + 200), DW'(i + 100), DW'(i)};
        end
    end

    always @(posedge clk) begin
        if (img_rd_en) begin
            img_rd_data <= mem[img_rd_addr];
        end
    end

    function automatic int relCycle();
        return int'((longint'($time) - t0 + 9) / PERIOD);
    endfunction

    function automatic logic [NF-1:0] fmPattern(input int cyc);
        logic [NF-1:0] v;
        v = '0;
        for (int i = 0; i < NF; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (fLo[i][j] > 0 && cyc >= fLo[i][j] && cyc <= fHi[i][j]) begin
                    v[i] = 1'b1;
                end
            end
        end
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [DW*3-1:0] act, input logic [DW*3-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, relCycle(), act, exp);
        end
    endtask

    task automatic setFm(input int f, input int aLo, input int aHi, input int bLo, input int bHi);
        fLo[f][0] = aLo;
        fHi[f][0] = aHi;
        fLo[f][1] = bLo;
        fHi[f][1] = bHi;
    endtask

    task automatic pushProbe(input int cyc, input int sig, input logic val);
        probe_t p;
        p.cyc = cyc;
        p.sig = sig;
        p.val = val;
        probeQ.push_back(p);
    endtask

    // Expected reads and writes of one layer whose edge 0 is at cycle off; nothing past cycle limit.
    task automatic pushLayer(input int off, input int sLo, input int sHi, input int limit);
        for (int k = 0; k < SIDE * SIDE; k++) begin
            int  r, c, iss, idx;
            bit  border;
            wr_t w;
            r      = k / SIDE;
            c      = k % SIDE;
            iss    = 1 + k + off;
            if (sLo > 0 && iss >= sLo) begin
                iss += sHi - sLo + 1;
            end
            border = (r == 0) || (r == SIDE - 1) || (c == 0) || (c == SIDE - 1);
            idx    = (r - 1) * W + (c - 1);
            if (iss <= limit && !border) begin
                addrQ.push_back(idx);
            end
            if (iss + 1 <= limit) begin
                w.data = border ? '0 : {DW'(idx + 200), DW'(idx + 100), DW'(idx)};
                w.cyc  = iss + 1;
                wrQ.push_back(w);
            end
        end
    endtask

    // Monitor: consumes the scoreboard queues whenever the DUT presents a write, read or done.
    always @(negedge clk) begin
        int     cur;
        wr_t    w;
        probe_t p;
        int     a;
        int     d;
        logic   sv;
        cur = relCycle();
        if (data_fifo_wren) begin
            if (wrQ.size() == 0) begin
                checkVal("unexpected write", data_fifo_wren, 0);
            end else begin
                w = wrQ.pop_front();
                checkVal("write data", data_out, w.data);
                checkVal("write cycle", cur, w.cyc);
            end
        end
        if (img_rd_en && !fifo_full) begin
            if (addrQ.size() == 0) begin
                checkVal("unexpected read", img_rd_en, 0);
            end else begin
                a = addrQ.pop_front();
                checkVal("read addr", img_rd_addr, a);
            end
        end
        if (done) begin
            if (doneQ.size() == 0) begin
                checkVal("unexpected done", done, 0);
            end else begin
                d = doneQ.pop_front();
                checkVal("done cycle", cur, d);
            end
        end
        if (active) begin
            while (probeQ.size() > 0 && probeQ[0].cyc <= cur) begin
                p  = probeQ.pop_front();
                sv = (p.sig == 0) ? busy : (p.sig == 1) ? done : err;
                checkVal((p.sig == 0) ? "busy probe" : (p.sig == 1) ? "done probe" : "err probe", sv, p.val);
            end
        end
    end

    // Runs one layer: start sampled at edge 0, then per-cycle drive of stall, filter pulses and reset.
    task automatic applyStimulus(input int lastCycle, input bit holdStart, input int startDrop);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        t0     = longint'($time);
        active = 1'b1;
        for (int cyc = 1; cyc <= lastCycle; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk);
            end
            #1;
            start     = holdStart && (cyc < startDrop);
            fifo_full = (stallLo > 0) && (cyc >= stallLo) && (cyc <= stallHi);
            fm_valid  = fmPattern(cyc);
            rst       = (rstAt > 0) && (cyc >= rstAt) && (cyc <= rstAt + 1);
            if (rstAt > 0 && cyc == rstAt) begin
                #1;
                checkVal("async rst img_rd_en", img_rd_en, 0);
                checkVal("async rst img_rd_addr", img_rd_addr, 0);
                checkVal("async rst data_out", data_out, 0);
                checkVal("async rst wren", data_fifo_wren, 0);
                checkVal("async rst busy", busy, 0);
                checkVal("async rst done", done, 0);
                checkVal("async rst err", err, 0);
            end
        end
        @(posedge clk);
        #1;
        active    = 1'b0;
        start     = 1'b0;
        fifo_full = 1'b0;
        fm_valid  = '0;
        rst       = 1'b0;
    endtask

    task automatic checkOutput(input string name);
        checkVal({name, " writes outstanding"}, wrQ.size(), 0);
        checkVal({name, " reads outstanding"}, addrQ.size(), 0);
        checkVal({name, " done outstanding"}, doneQ.size(), 0);
        checkVal({name, " probes outstanding"}, probeQ.size(), 0);
        wrQ.delete();
        addrQ.delete();
        doneQ.delete();
        probeQ.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        fifo_full = 1'b0;
        fm_valid  = '0;
        setFm(0, 0, 0, 0, 0);
        setFm(1, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("reset img_rd_en", img_rd_en, 0);
        checkVal("reset img_rd_addr", img_rd_addr, 0);
        checkVal("reset data_out", data_out, 0);
        checkVal("reset wren", data_fifo_wren, 0);
        checkVal("reset busy", busy, 0);
        checkVal("reset done", done, 0);
        checkVal("reset err", err, 0);
        rst = 1'b0;

        // Plain layer: 36 writes in cycles 2..37, done two cycles after the last write.
        setFm(0, 3, 18, 0, 0);
        setFm(1, 3, 18, 0, 0);
        pushLayer(0, 0, 0, 1000);
        doneQ.push_back(39);
        pushProbe(1, 0, 1'b1);
        pushProbe(38, 0, 1'b1);
        pushProbe(38, 1, 1'b0);
        pushProbe(40, 0, 1'b0);
        pushProbe(40, 2, 1'b0);
        applyStimulus(42, 1'b0, 0);
        checkOutput("plain");

        // fifo_full during cycles 10..14 shifts every later issue by five cycles.
        stallLo = 10;
        stallHi = 14;
        pushLayer(0, 10, 14, 1000);
        doneQ.push_back(44);
        pushProbe(40, 0, 1'b1);
        pushProbe(45, 0, 1'b0);
        applyStimulus(47, 1'b0, 0);
        checkOutput("stall");
        stallLo = 0;
        stallHi = 0;

        // Filter 1 short by one pulse until cycle 50.
        setFm(0, 3, 18, 0, 0);
        setFm(1, 3, 17, 50, 50);
        pushLayer(0, 0, 0, 1000);
        doneQ.push_back(51);
        pushProbe(38, 1, 1'b0);
        pushProbe(50, 0, 1'b1);
        pushProbe(50, 1, 1'b0);
        pushProbe(52, 0, 1'b0);
        pushProbe(52, 1, 1'b0);
        applyStimulus(54, 1'b0, 0);
        checkOutput("late pulse");

        // Seventeenth pulse on filter 0 raises a sticky err without disturbing done.
        setFm(0, 3, 19, 0, 0);
        setFm(1, 3, 18, 0, 0);
        pushLayer(0, 0, 0, 1000);
        doneQ.push_back(39);
        pushProbe(19, 2, 1'b0);
        pushProbe(20, 2, 1'b1);
        pushProbe(40, 0, 1'b0);
        pushProbe(41, 2, 1'b1);
        applyStimulus(43, 1'b0, 0);
        checkOutput("overflow");

        // start held high: second layer begins at edge 40 with counters and err cleared.
        setFm(0, 3, 19, 80, 95);
        setFm(1, 3, 18, 80, 95);
        pushLayer(0, 0, 0, 1000);
        pushLayer(40, 0, 0, 1000);
        doneQ.push_back(39);
        doneQ.push_back(96);
        pushProbe(20, 2, 1'b1);
        pushProbe(40, 0, 1'b0);
        pushProbe(41, 0, 1'b1);
        pushProbe(41, 2, 1'b0);
        pushProbe(79, 0, 1'b1);
        pushProbe(79, 1, 1'b0);
        pushProbe(97, 0, 1'b0);
        pushProbe(98, 0, 1'b0);
        applyStimulus(100, 1'b1, 50);
        checkOutput("held start");

        // Reset in cycle 20 drops the in-flight write and leaves the block idle.
        setFm(0, 0, 0, 0, 0);
        setFm(1, 0, 0, 0, 0);
        rstAt = 20;
        pushLayer(0, 0, 0, 19);
        pushProbe(23, 0, 1'b0);
        pushProbe(23, 2, 1'b0);
        applyStimulus(25, 1'b0, 0);
        checkOutput("mid reset");
        rstAt = 0;

        // Clean layer after the reset.
        setFm(0, 3, 18, 0, 0);
        setFm(1, 3, 18, 0, 0);
        pushLayer(0, 0, 0, 1000);
        doneQ.push_back(39);
        pushProbe(40, 0, 1'b0);
        applyStimulus(42, 1'b0, 0);
        checkOutput("after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
